// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: a Booth encoder on the latched multiplier
// and a shift/accumulate datapath that retires one encoded digit per clock.

module booth_radix4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           b_i,
  input  logic                       unsigned_i,
  output logic [3*(WIDTH/2+1)-1:0]   enc_o
);

  localparam int NDIG = WIDTH / 2 + 1;

  logic [2*NDIG:0] bExt;
  logic            b2, b1, b0;

  // Multiplier widened by two bits (sign or zero fill) plus the implicit zero below the LSB
  assign bExt = {{2{~unsigned_i & b_i[WIDTH-1]}}, b_i, 1'b0};

  always_comb begin
    enc_o = '0;
    b2    = 1'b0;
    b1    = 1'b0;
    b0    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      b2 = bExt[2*i+2];
      b1 = bExt[2*i+1];
      b0 = bExt[2*i];
      enc_o[3*i+2] = b2 & ~(b1 & b0);
      enc_o[3*i+1] = (b2 == b1) && (b1 == b0);
      enc_o[3*i]   = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
    end
  end

endmodule

module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 unsigned_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]     aLat_q, aLat_d;
  logic [WIDTH-1:0]     bLat_q, bLat_d;
  logic                 uns_q, uns_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [3*NDIG-1:0]    enc;
  logic [2:0]           digit;
  logic [WIDTH:0]       extA;
  logic [WIDTH+1:0]     mag;
  logic [WIDTH+1:0]     pp;
  logic [AW-1:0]        ppShift;
  logic [AW-1:0]        accSum;

  booth_radix4 #(.WIDTH(WIDTH)) uEnc (
    .b_i        (bLat_q),
    .unsigned_i (uns_q),
    .enc_o      (enc)
  );

  // Partial product for the current digit, sign-extended and aligned to weight 4^cnt
  always_comb begin
    digit   = enc[3*cnt_q +: 3];
    extA    = {~uns_q & aLat_q[WIDTH-1], aLat_q};
    mag     = digit[1] ? '0 : (digit[0] ? {extA, 1'b0} : {extA[WIDTH], extA});
    pp      = digit[2] ? -mag : mag;
    ppShift = {{(AW-WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt_q, 1'b0};
    accSum  = acc_q + ppShift;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    aLat_d  = aLat_q;
    bLat_d  = bLat_q;
    uns_d   = uns_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          aLat_d  = a_i;
          bLat_d  = b_i;
          uns_d   = unsigned_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = accSum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG-1)) begin
          cnt_d   = '0;
          prod_d  = accSum[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including an accept or the final accumulate
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      aLat_d  = aLat_q;
      bLat_d  = bLat_q;
      uns_d   = uns_q;
      prod_d  = prod_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      aLat_q <= '0;
      bLat_q <= '0;
      uns_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      aLat_q <= aLat_d;
      bLat_q <= bLat_d;
      uns_q  <= uns_d;
      prod_q <= prod_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign prod_o      = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (WIDTH=8): products, latency, backpressure,
// flush and asynchronous reset, with hand-computed expectations.

module tb_booth_mul_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        unsigned_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] prod_o;

  int compCount = 0;
  int failCount = 0;

  booth_mul_seq #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .unsigned_i  (unsigned_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .prod_o      (prod_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic uns);
    a_i        = a;
    b_i        = b;
    unsigned_i = uns;
    in_valid_i = 1'b1;
  endtask

  // Present an operand pair at a falling edge and step past the accept edge
  task automatic startOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic uns);
    checkOutput({tag, " idle ready"}, in_ready_o, 1);
    applyStimulus(a, b, uns);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    a_i        = 8'hA5;
    b_i        = 8'h5A;
    unsigned_i = ~uns;
    checkOutput({tag, " busy ready"}, in_ready_o, 0);
    checkOutput({tag, " busy valid"}, out_valid_o, 0);
  endtask

  task automatic waitValid(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 5);
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic uns, input logic [15:0] expProd, input int holdCycles);
    startOp(tag, a, b, uns);
    waitValid(tag);
    checkOutput({tag, " prod"}, prod_o, expProd);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk_i);
      checkOutput({tag, " hold valid"}, out_valid_o, 1);
      checkOutput({tag, " hold prod"}, prod_o, expProd);
      checkOutput({tag, " hold ready"}, in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checkOutput({tag, " retired valid"}, out_valid_o, 0);
    checkOutput({tag, " ready again"}, in_ready_o, 1);
  endtask

  // Raise reset between clock edges and look at the outputs before any edge arrives
  task automatic asyncReset(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput({tag, " valid"}, out_valid_o, 0);
    checkOutput({tag, " ready"}, in_ready_o, 1);
    checkOutput({tag, " prod"}, prod_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic expectNoValid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    checkOutput({tag, " no valid pulse"}, seen, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    a_i         = '0;
    b_i         = '0;
    unsigned_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset valid", out_valid_o, 0);
    checkOutput("reset ready", in_ready_o, 1);
    checkOutput("reset prod", prod_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    runOp("s -3*5", 8'hFD, 8'h05, 1'b0, 16'hFFF1, 0);
    runOp("u ff*ff", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 0);
    runOp("s -1*-1", 8'hFF, 8'hFF, 1'b0, 16'h0001, 0);
    runOp("s 80*80", 8'h80, 8'h80, 1'b0, 16'h4000, 0);
    runOp("u c8*03", 8'hC8, 8'h03, 1'b1, 16'h0258, 0);
    runOp("backpressure", 8'h0C, 8'hF9, 1'b0, 16'hFFAC, 7);

    startOp("flush busy", 8'h33, 8'h44, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush busy ready", in_ready_o, 1);
    checkOutput("flush busy valid", out_valid_o, 0);
    expectNoValid("flush busy", 8);
    runOp("after flush", 8'h07, 8'h06, 1'b0, 16'h002A, 0);

    applyStimulus(8'h11, 8'h11, 1'b0);
    flush_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    checkOutput("flush idle ready", in_ready_o, 1);
    expectNoValid("flush idle", 7);

    startOp("rst busy", 8'h55, 8'h22, 1'b0);
    @(negedge clk_i);
    asyncReset("rst busy");
    startOp("rst done", 8'h09, 8'h09, 1'b1);
    waitValid("rst done");
    checkOutput("rst done prod", prod_o, 16'h0051);
    asyncReset("rst done");
    runOp("after rst", 8'h10, 8'hF0, 1'b0, 16'hFF00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
